// File: rtl/output_layer_sequencer.sv
// Final-stage sequencer: buffers hidden activations, steps the neuron engine once per class, tracks the float argmax.
// Optional SCORE_RELU_EN: clamp negative class scores to +0 before ranking and reporting.
module output_layer_sequencer #(
    parameter int NUM_HIDDEN  = 5,
    parameter int NUM_CLASSES = 10,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hid_we,
    input  logic [2:0]        hid_waddr,
    input  logic [31:0]       hid_wdata,
    input  logic [2:0]        neuron_idx,
    output logic [31:0]       neuron_pxl,
    output logic              neuron_start,
    input  logic              neuron_done,
    input  logic [31:0]       neuron_out,
    output logic [3:0]        class_id,
    output logic [ADDR_W-1:0] weight_base,
    output logic [31:0]       best_score,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [3:0]        NH_L       = 4'(NUM_HIDDEN);
    localparam logic [3:0]        LAST_CLASS = 4'(NUM_CLASSES - 1);
    localparam logic [ADDR_W-1:0] BASE_STEP  = ADDR_W'(NUM_HIDDEN + 1);

    state_t      state;
    logic [31:0] hid_buf [NUM_HIDDEN];
    logic [3:0]  best_class;
    logic        best_valid;
    logic [31:0] score_in;
    logic        score_better;
    logic        wr_ok;
    logic        rd_ok;

    // Maps IEEE-754 bit patterns onto an unsigned ordering: negatives are
    // inverted so larger magnitude sorts lower, positives get the top bit set.
    function automatic logic [31:0] score_key(input logic [31:0] s);
        return s[31] ? ~s : {1'b1, s[30:0]};
    endfunction

`ifdef SCORE_RELU_EN
    assign score_in = neuron_out[31] ? 32'h0 : neuron_out;
`else
    assign score_in = neuron_out;
`endif

    assign score_better = !best_valid || (score_key(score_in) > score_key(best_score));

    assign neuron_start = (state == RUN);
    assign busy         = (state != IDLE);
    assign done         = (state == FINISH);

    assign wr_ok = hid_we && !busy && ({1'b0, hid_waddr} < NH_L);
    assign rd_ok = ({1'b0, neuron_idx} < NH_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_HIDDEN; i++) begin
                hid_buf[i] <= '0;
            end
        end else if (wr_ok) begin
            hid_buf[hid_waddr] <= hid_wdata;
        end
    end

    // Read sees the pre-write contents when the same index is written this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            neuron_pxl <= '0;
        end else if (rd_ok) begin
            neuron_pxl <= hid_buf[neuron_idx];
        end else begin
            neuron_pxl <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            class_id    <= '0;
            weight_base <= '0;
            best_score  <= '0;
            best_class  <= '0;
            best_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        class_id    <= '0;
                        weight_base <= '0;
                        best_score  <= '0;
                        best_class  <= '0;
                        best_valid  <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (neuron_done) begin
                        if (score_better) begin
                            best_score <= score_in;
                            best_class <= class_id;
                            best_valid <= 1'b1;
                        end
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Engine must drop its done before the next class may start.
                    if (!neuron_done) begin
                        if (class_id == LAST_CLASS) begin
                            class_id <= best_class;
                            state    <= FINISH;
                        end else begin
                            class_id    <= class_id + 4'd1;
                            weight_base <= weight_base + BASE_STEP;
                            state       <= RUN;
                        end
                    end
                end
                FINISH: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
